// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction-fetch port, data port and
// the shared single-port memory side.
// slave  : the arbiter's view (drives acks, read data and memory enables).
// master : the environment's view (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Instruction-fetch requester (read only)
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;

    // Data load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    // Unified memory
    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter status
    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_re, mem_we, mem_addr,
               mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_re, mem_we, mem_addr,
               mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction-fetch (I) and data (D) accesses
// onto one single-port memory with a ReadEnable/WriteEnable -> Ack handshake.
// One transaction in flight; IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional macro MEM_PORT_ARBITER_ROUND_ROBIN_EN: alternate grants on
// simultaneous requests instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic                  grant_d;   // 1 = D port owns the current transaction
    logic                  grant_we;  // current transaction is a D write
    logic                  pick_d;    // arbitration result for this IDLE cycle

    logic                  i_ack_q;
    logic                  d_ack_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  busy_q;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic                  last_served;  // 0 = I, 1 = D

    // On a tie, grant whichever port was not served last; a lone request always wins
    always_comb begin
        pick_d = bus.d_req && (!bus.i_req || !last_served);
    end
`else
    // Fixed priority: D wins whenever it is requesting
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    // Arbitration FSM with all bus-facing outputs registered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: datapath registers are reset too, so every output reads 0
            // out of reset rather than X.
            state       <= IDLE;
            grant_d     <= 1'b0;
            grant_we    <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
            last_served <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge register values.
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        grant_d     <= pick_d;
                        grant_we    <= pick_d && bus.d_we;
                        mem_addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
                        mem_wdata_q <= pick_d ? bus.d_wdata : '0;
                        mem_re_q    <= !(pick_d && bus.d_we);
                        mem_we_q    <= pick_d && bus.d_we;
                        busy_q      <= 1'b1;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
                        last_served <= pick_d;
`endif
                        state       <= ISSUE;
                    end
                end
                // ISSUE accepts mem_ack too, so zero-wait memories finish a cycle early
                ISSUE, WAIT: begin
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (bus.mem_ack) begin
                        if (grant_d) begin
                            d_ack_q <= 1'b1;
                            if (!grant_we) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                // Requests are not sampled here; a stray mem_ack is ignored
                RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural memory with programmable
// latency, directed requester sequences, and an ack scoreboard holding the
// expected port and read data for every transaction in grant order.
module tb_mem_port_arbiter;

    logic CLK;
    logic RST;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic        port;   // 0 = I, 1 = D
        logic [31:0] data;   // rdata expected on that port at ack
    } sb_t;

    sb_t         sb[$];
    int          tests;
    int          failed;
    int          re_cnt;
    logic        prev_en;
    logic        mem_auto;
    logic        stray_req;
    int          mem_delay;   // -1 zero-wait, 0 one-cycle, N extra cycles

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [135:0] outs();
        return {3'b0, bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata, bus.mem_re,
                bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
    endfunction

    // Memory model: reacts to an enable seen at a falling edge
    initial begin
        logic [31:0] mem_img [logic [31:0]];
        logic [31:0] a;
        logic        w;
        mem_img[32'h08] = 32'h2002_0005;
        mem_img[32'h0C] = 32'h3003_0007;
        mem_img[32'h10] = 32'h1111_2222;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (stray_req) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
                @(negedge CLK);
                bus.mem_ack = 1'b0;
            end else if (mem_auto && (bus.mem_re || bus.mem_we)) begin
                a = bus.mem_addr;
                w = bus.mem_we;
                if (w) mem_img[a] = bus.mem_wdata;
                if (mem_delay >= 0) repeat (mem_delay + 1) @(negedge CLK);
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = w ? 32'h0 : (mem_img.exists(a) ? mem_img[a] : pattern(a));
                @(negedge CLK);
                bus.mem_ack = 1'b0;
            end
        end
    end

    // Monitor: enable pulse width, ack exclusivity, scoreboard compare
    initial begin
        sb_t e;
        prev_en = 1'b0;
        re_cnt  = 0;
        forever begin
            @(negedge CLK);
            if (bus.mem_re) re_cnt++;
            if (bus.mem_re || bus.mem_we) begin
                check("en_pulse_width", {135'b0, prev_en}, 136'd0);
                check("re_we_excl", {135'b0, bus.mem_re & bus.mem_we}, 136'd0);
            end
            prev_en = bus.mem_re | bus.mem_we;
            if (bus.i_ack || bus.d_ack) begin
                check("ack_excl", {135'b0, bus.i_ack & bus.d_ack}, 136'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", {134'b0, bus.i_ack, bus.d_ack}, 136'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", {135'b0, bus.d_ack}, {135'b0, e.port});
                    check("ack_rdata", {104'b0, e.port ? bus.d_rdata : bus.i_rdata},
                          {104'b0, e.data});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Waits at falling edges for the port's ack; cycles = 0 means timed out
    task automatic wait_ack(input logic port, input int budget, output int cycles);
        cycles = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLK);
            if (port ? bus.d_ack : bus.i_ack) begin
                cycles = k;
                break;
            end
        end
        check(port ? "d_ack_timeout" : "i_ack_timeout", {135'b0, cycles != 0}, 136'd1);
    endtask

    task automatic i_access(input logic [31:0] addr, input logic keep, output int lat);
        bus.i_addr = addr;
        bus.i_req  = 1'b1;
        wait_ack(1'b0, 60, lat);
        if (!keep) bus.i_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic keep, output int lat);
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        wait_ack(1'b1, 60, lat);
        if (!keep) bus.d_req = 1'b0;
    endtask

    initial begin
        int lat;
        int lat_i0, lat_i1, lat_d0, lat_d1;
        int re_before;
        int k;
        tests     = 0;
        failed    = 0;
        mem_auto  = 1'b1;
        stray_req = 1'b0;
        mem_delay = 0;
        RST       = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset_outs", outs(), 136'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single I read with cycle-exact timing
        sb.push_back('{1'b0, 32'h2002_0005});
        bus.i_addr = 32'h08;
        bus.i_req  = 1'b1;
        @(posedge CLK); #1;
        check("i_issue", {103'b0, bus.mem_re, bus.mem_we, bus.busy, bus.mem_addr},
              {103'b0, 1'b1, 1'b0, 1'b1, 32'h08});
        @(posedge CLK); #1;
        check("i_re_cleared", {135'b0, bus.mem_re}, 136'd0);
        @(posedge CLK); #1;
        check("i_resp", {102'b0, bus.i_ack, bus.d_ack, bus.i_rdata}, {102'b0, 2'b10, 32'h2002_0005});
        bus.i_req = 1'b0;
        @(posedge CLK); #1;
        check("i_idle", {134'b0, bus.i_ack, bus.busy}, 136'd0);
        @(negedge CLK);

        // D read, one-cycle memory latency
        sb.push_back('{1'b1, 32'h1111_2222});
        d_access(1'b0, 32'h10, 32'h0, 1'b0, lat);
        check("d_read_latency", lat, 3);
        @(negedge CLK);

        // D write: no read enable, d_rdata untouched
        sb.push_back('{1'b1, 32'h1111_2222});
        re_before   = re_cnt;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_req   = 1'b1;
        @(negedge CLK);
        check("d_write_issue", {70'b0, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
              {70'b0, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF});
        wait_ack(1'b1, 60, lat);
        bus.d_req = 1'b0;
        check("d_write_no_re", re_cnt, re_before);
        check("d_write_rdata_kept", bus.d_rdata, 32'h1111_2222);
        @(negedge CLK);

        // Read back what was written
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        d_access(1'b0, 32'h40, 32'h0, 1'b0, lat);
        @(negedge CLK);

        // Slow memory: ack five cycles late
        mem_delay = 5;
        sb.push_back('{1'b1, pattern(32'h20)});
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h20;
        bus.d_req  = 1'b1;
        @(negedge CLK);
        check("slow_re", {135'b0, bus.mem_re}, 136'd1);
        lat = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.mem_ack) begin
                lat = k;
                break;
            end
            check("slow_hold", {102'b0, bus.busy, bus.mem_re, bus.mem_addr},
                  {102'b0, 1'b1, 1'b0, 32'h20});
        end
        check("slow_ack_delay", lat, 6);
        @(negedge CLK);
        check("slow_d_ack", {134'b0, bus.d_ack, bus.busy}, {134'b0, 2'b11});
        bus.d_req = 1'b0;
        mem_delay = 0;
        @(negedge CLK);

        // Zero-wait memory: ack accepted in ISSUE
        mem_delay = -1;
        sb.push_back('{1'b0, pattern(32'h14)});
        i_access(32'h14, 1'b0, lat);
        check("zero_wait_latency", lat, 2);
        mem_delay = 0;
        @(negedge CLK);

        // I request held across RESP with a new address
        sb.push_back('{1'b0, 32'h2002_0005});
        sb.push_back('{1'b0, 32'h3003_0007});
        i_access(32'h08, 1'b1, lat);
        bus.i_addr = 32'h0C;
        @(negedge CLK);
        check("held_idle", {134'b0, bus.mem_re, bus.busy}, 136'd0);
        @(negedge CLK);
        check("held_reissue", {103'b0, bus.mem_re, bus.mem_addr}, {103'b0, 1'b1, 32'h0C});
        wait_ack(1'b0, 60, lat);
        bus.i_req = 1'b0;
        @(negedge CLK);

        // Reset in WAIT, then a stray ack
        mem_auto   = 1'b0;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h30;
        bus.d_req  = 1'b1;
        @(negedge CLK);
        check("rst_issue", {135'b0, bus.mem_re}, 136'd1);
        repeat (2) @(negedge CLK);
        check("rst_wait_busy", {135'b0, bus.busy}, 136'd1);
        #2;
        RST       = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 136'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK); #1;
        stray_req = 1'b1;
        @(negedge CLK); #1;
        stray_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK);
            check("stray_no_ack", {133'b0, bus.i_ack, bus.d_ack, bus.busy}, 136'd0);
        end
        mem_auto = 1'b1;

        // Simultaneous requests, two back-to-back accesses per port
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        sb.push_back('{1'b1, pattern(32'h200)});
        sb.push_back('{1'b0, pattern(32'h100)});
        sb.push_back('{1'b1, pattern(32'h204)});
        sb.push_back('{1'b0, pattern(32'h104)});
`else
        sb.push_back('{1'b1, pattern(32'h200)});
        sb.push_back('{1'b1, pattern(32'h204)});
        sb.push_back('{1'b0, pattern(32'h100)});
        sb.push_back('{1'b0, pattern(32'h104)});
`endif
        fork
            begin
                i_access(32'h100, 1'b1, lat_i0);
                i_access(32'h104, 1'b0, lat_i1);
            end
            begin
                d_access(1'b0, 32'h200, 32'h0, 1'b1, lat_d0);
                d_access(1'b0, 32'h204, 32'h0, 1'b0, lat_d1);
            end
        join
        check("dual_first_d_latency", lat_d0, 3);
        repeat (3) @(negedge CLK);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
